// File: rtl/matrix_bank_buffer.sv
// Multi-slot row-serial matrix buffer: rows are written into independent slots, and full slots are read out as whole matrices.
// Optional column-major readout is enabled by defining MATRIX_BANK_TRANSPOSE_EN.
module matrix_bank_buffer #(
    parameter int INPUT_WIDTH = 8,
    parameter int MATRIX_SIZE = 3,
    parameter int NUM_SLOTS   = 4,
    parameter int SLOT_W      = $clog2(NUM_SLOTS)
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        wr_valid,
    output logic                                        wr_ready,
    input  logic [SLOT_W-1:0]                           wr_slot,
    input  logic [INPUT_WIDTH*MATRIX_SIZE-1:0]          wr_row,
    input  logic                                        rd_req,
    output logic                                        rd_ready,
    input  logic [SLOT_W-1:0]                           rd_slot,
    input  logic                                        rd_release,
    input  logic                                        rd_transpose,
    output logic                                        rd_valid,
    output logic [INPUT_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] MATRIX_OUTPUT,
    output logic [NUM_SLOTS-1:0]                        slot_full,
    output logic                                        wr_drop
);
    localparam int ROW_W = INPUT_WIDTH * MATRIX_SIZE;
    localparam int OUT_W = ROW_W * MATRIX_SIZE;
    localparam int DEPTH = NUM_SLOTS * MATRIX_SIZE;
    localparam int PTR_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [ROW_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr [NUM_SLOTS];
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_fire;
    logic             rd_fire;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_base;
    logic [OUT_W-1:0] rd_data;

    assign wr_in_range = (int'(wr_slot) < NUM_SLOTS);
    assign rd_in_range = (int'(rd_slot) < NUM_SLOTS);
    assign wr_ready    = wr_in_range && !slot_full[wr_slot];
    assign rd_ready    = rd_in_range && slot_full[rd_slot];
    assign wr_fire     = wr_valid && wr_ready;
    assign rd_fire     = rd_req && rd_ready;

    // Out-of-range slot indices are clamped to 0 so the storage index never leaves the array.
    always_comb begin
        wr_idx  = '0;
        rd_base = '0;
        if (wr_in_range)
            wr_idx = IDX_W'(int'(wr_slot) * MATRIX_SIZE + int'(ptr[wr_slot]));
        if (rd_in_range)
            rd_base = IDX_W'(int'(rd_slot) * MATRIX_SIZE);
    end

`ifdef MATRIX_BANK_TRANSPOSE_EN
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                if (rd_transpose)
                    rd_data[OUT_W-1-(i*MATRIX_SIZE+j)*INPUT_WIDTH -: INPUT_WIDTH] =
                        mem[int'(rd_base)+j][ROW_W-1-i*INPUT_WIDTH -: INPUT_WIDTH];
                else
                    rd_data[OUT_W-1-(i*MATRIX_SIZE+j)*INPUT_WIDTH -: INPUT_WIDTH] =
                        mem[int'(rd_base)+i][ROW_W-1-j*INPUT_WIDTH -: INPUT_WIDTH];
            end
        end
    end
`else
    logic unused_transpose;
    assign unused_transpose = rd_transpose;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < MATRIX_SIZE; i++)
            rd_data[OUT_W-1-i*ROW_W -: ROW_W] = mem[int'(rd_base)+i];
    end
`endif

    // A write to a slot that is being released in the same cycle sees the slot as full and is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
            for (int s = 0; s < NUM_SLOTS; s++)
                ptr[s] <= '0;
            slot_full     <= '0;
            MATRIX_OUTPUT <= '0;
            rd_valid      <= 1'b0;
            wr_drop       <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            wr_drop  <= wr_valid && !wr_ready;
            if (wr_fire) begin
                mem[wr_idx] <= wr_row;
                if (ptr[wr_slot] == PTR_W'(MATRIX_SIZE - 1)) begin
                    ptr[wr_slot]       <= '0;
                    slot_full[wr_slot] <= 1'b1;
                end else begin
                    ptr[wr_slot] <= ptr[wr_slot] + 1'b1;
                end
            end
            if (rd_fire) begin
                MATRIX_OUTPUT <= rd_data;
                if (rd_release) begin
                    ptr[rd_slot]       <= '0;
                    slot_full[rd_slot] <= 1'b0;
                end
            end
        end
    end
endmodule
